// File: rtl/blk_e0b9f1_if.sv
// BCAM MBIST response-handler bus: compare issue/expectation inputs, array match vector,
// clear strobe and the fail/diagnostic status returned to the MBIST controller.
// Optional: BCAM_MBIST_OUTHANDLER_DIAG_EN adds the first-fail XOR vector output.
interface blk_e0b9f1_if #(
  parameter int unsigned RF_ENTRIES    = 128,
  parameter int unsigned RF_AWIDTH     = 7,
  parameter int unsigned FAILCNT_WIDTH = 8
);
  logic                     BIST_CM_MODE_RF_IN;
  logic [1:0]               BIST_CM_EXP_MODE_RF_IN;
  logic [RF_AWIDTH-1:0]     BIST_CM_EXP_ADDR_RF_IN;
  logic [RF_ENTRIES-1:0]    CM_MATCH_RF_IN;
  logic                     BIST_CMP_CLR_RF_IN;
  logic                     BIST_CM_FAIL_RF_OUT;
  logic                     BIST_CM_GO_ID_RF_OUT;
  logic [FAILCNT_WIDTH-1:0] BIST_CM_FAIL_CNT_RF_OUT;
  logic [RF_AWIDTH-1:0]     BIST_CM_FF_ADDR_RF_OUT;
`ifdef BCAM_MBIST_OUTHANDLER_DIAG_EN
  logic [RF_ENTRIES-1:0]    BIST_CM_FAIL_VEC_RF_OUT;
`endif

  // Controller / array side
  modport master (
    output BIST_CM_MODE_RF_IN, BIST_CM_EXP_MODE_RF_IN, BIST_CM_EXP_ADDR_RF_IN,
           CM_MATCH_RF_IN, BIST_CMP_CLR_RF_IN,
    input  BIST_CM_FAIL_RF_OUT, BIST_CM_GO_ID_RF_OUT, BIST_CM_FAIL_CNT_RF_OUT,
           BIST_CM_FF_ADDR_RF_OUT
`ifdef BCAM_MBIST_OUTHANDLER_DIAG_EN
         , BIST_CM_FAIL_VEC_RF_OUT
`endif
  );

  // Response handler side
  modport slave (
    input  BIST_CM_MODE_RF_IN, BIST_CM_EXP_MODE_RF_IN, BIST_CM_EXP_ADDR_RF_IN,
           CM_MATCH_RF_IN, BIST_CMP_CLR_RF_IN,
    output BIST_CM_FAIL_RF_OUT, BIST_CM_GO_ID_RF_OUT, BIST_CM_FAIL_CNT_RF_OUT,
           BIST_CM_FF_ADDR_RF_OUT
`ifdef BCAM_MBIST_OUTHANDLER_DIAG_EN
         , BIST_CM_FAIL_VEC_RF_OUT
`endif
  );
endinterface

// File: rtl/blk_e0b9f1.sv
// BCAM MBIST output handler: delays the expected compare result by the array compare
// latency, checks the returned match vector and keeps fail pulse, sticky flag, saturating
// fail count and first-fail entry index.
// Optional: `define BCAM_MBIST_OUTHANDLER_DIAG_EN to also keep the first-fail XOR vector.
module blk_e0b9f1 #(
  parameter int unsigned RF_ENTRIES    = 128,
  parameter int unsigned RF_AWIDTH     = 7,
  parameter int unsigned CM_LATENCY    = 1,
  parameter int unsigned FAILCNT_WIDTH = 8
) (
  input  logic           bist_clk,
  input  logic           rst,
  blk_e0b9f1_if.slave    bus
);

  localparam logic [1:0]               MODE_NONE = 2'b00;
  localparam logic [1:0]               MODE_ONE  = 2'b01;
  localparam logic [1:0]               MODE_ALL  = 2'b10;
  localparam logic [FAILCNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef struct packed {
    logic                 vld;
    logic [1:0]           mode;
    logic [RF_AWIDTH-1:0] addr;
  } exp_stage_t;

  exp_stage_t [CM_LATENCY-1:0] pipe_q, pipe_d;
  exp_stage_t                  stage_in, stage_out;

  logic [RF_ENTRIES-1:0]    exp_vec, xor_vec;
  logic                     suppress, cmp_fail;
  logic [RF_AWIDTH-1:0]     lsb_idx;

  logic                     fail_q, fail_d;
  logic                     go_id_q, go_id_d;
  logic [FAILCNT_WIDTH-1:0] fail_cnt_q, fail_cnt_d;
  logic [RF_AWIDTH-1:0]     ff_addr_q, ff_addr_d;
`ifdef BCAM_MBIST_OUTHANDLER_DIAG_EN
  logic [RF_ENTRIES-1:0]    fail_vec_q, fail_vec_d;
`endif

  assign stage_in  = {bus.BIST_CM_MODE_RF_IN, bus.BIST_CM_EXP_MODE_RF_IN, bus.BIST_CM_EXP_ADDR_RF_IN};
  assign stage_out = pipe_q[CM_LATENCY-1];

  // Expectation shift path, one stage per cycle of array compare latency
  if (CM_LATENCY == 1) begin : g_lat1
    assign pipe_d = stage_in;
  end else begin : g_latn
    assign pipe_d = {pipe_q[CM_LATENCY-2:0], stage_in};
  end

  // Expectation pipeline registers; reset discards compares in flight
  always_ff @(posedge bist_clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Build the expected match vector for the aligned compare and flag a mismatch
  always_comb begin
    exp_vec  = '0;
    suppress = 1'b0;
    case (stage_out.mode)
      MODE_NONE: exp_vec = '0;
      MODE_ONE: begin
        if (32'(stage_out.addr) >= RF_ENTRIES) begin
          suppress = 1'b1;
        end else begin
          exp_vec[stage_out.addr] = 1'b1;
        end
      end
      MODE_ALL:  exp_vec = '1;
      default:   suppress = 1'b1;
    endcase
    xor_vec  = bus.CM_MATCH_RF_IN ^ exp_vec;
    cmp_fail = stage_out.vld && !suppress && (|xor_vec);
  end

  // Index of the lowest mismatching entry
  always_comb begin
    logic [RF_ENTRIES-1:0] scan;
    logic                  found;
    scan    = xor_vec;
    found   = 1'b0;
    lsb_idx = '0;
    for (int unsigned i = 0; i < RF_ENTRIES; i++) begin
      if (!found && scan[0]) begin
        lsb_idx = RF_AWIDTH'(i);
        found   = 1'b1;
      end
      scan = scan >> 1;
    end
  end

  // Status next state: clear beats a coincident fail, but the pulse still goes out
  always_comb begin
    fail_d     = cmp_fail;
    go_id_d    = go_id_q;
    fail_cnt_d = fail_cnt_q;
    ff_addr_d  = ff_addr_q;
`ifdef BCAM_MBIST_OUTHANDLER_DIAG_EN
    fail_vec_d = fail_vec_q;
`endif
    if (bus.BIST_CMP_CLR_RF_IN) begin
      go_id_d    = 1'b0;
      fail_cnt_d = '0;
      ff_addr_d  = '0;
`ifdef BCAM_MBIST_OUTHANDLER_DIAG_EN
      fail_vec_d = '0;
`endif
    end else if (cmp_fail) begin
      go_id_d = 1'b1;
      if (fail_cnt_q != CNT_MAX) begin
        fail_cnt_d = fail_cnt_q + FAILCNT_WIDTH'(1);
      end
      if (!go_id_q) begin
        ff_addr_d  = lsb_idx;
`ifdef BCAM_MBIST_OUTHANDLER_DIAG_EN
        fail_vec_d = xor_vec;
`endif
      end
    end
  end

  // Status registers
  always_ff @(posedge bist_clk or posedge rst) begin
    if (rst) begin
      fail_q     <= 1'b0;
      go_id_q    <= 1'b0;
      fail_cnt_q <= '0;
      ff_addr_q  <= '0;
`ifdef BCAM_MBIST_OUTHANDLER_DIAG_EN
      fail_vec_q <= '0;
`endif
    end else begin
      fail_q     <= fail_d;
      go_id_q    <= go_id_d;
      fail_cnt_q <= fail_cnt_d;
      ff_addr_q  <= ff_addr_d;
`ifdef BCAM_MBIST_OUTHANDLER_DIAG_EN
      fail_vec_q <= fail_vec_d;
`endif
    end
  end

  assign bus.BIST_CM_FAIL_RF_OUT     = fail_q;
  assign bus.BIST_CM_GO_ID_RF_OUT    = go_id_q;
  assign bus.BIST_CM_FAIL_CNT_RF_OUT = fail_cnt_q;
  assign bus.BIST_CM_FF_ADDR_RF_OUT  = ff_addr_q;
`ifdef BCAM_MBIST_OUTHANDLER_DIAG_EN
  assign bus.BIST_CM_FAIL_VEC_RF_OUT = fail_vec_q;
`endif

endmodule

// File: tb/tb_blk_e0b9f1.sv
// Bench for blk_e0b9f1: two instances (compare latency 1 and 4) share the issue stream;
// each gets its own match vector delayed by its latency. Per-cycle expected compare
// outcomes go into per-instance queues; a negedge monitor pops them and tracks status.
module tb_blk_e0b9f1;

  localparam int unsigned N    = 128;
  localparam int unsigned AW   = 7;
  localparam int unsigned CW   = 8;
  localparam int unsigned MAXC = 4096;
  localparam int          CNT_MAX = 255;

  typedef struct {
    int           due;
    bit           fail;
    int           idx;
    logic [N-1:0] xv;
  } outcome_t;

  logic          bist_clk = 1'b0;
  logic          rst      = 1'b1;
  logic          mode_v   = 1'b0;
  logic [1:0]    exp_mode = 2'b00;
  logic [AW-1:0] exp_addr = '0;
  logic          clr      = 1'b0;
  logic [N-1:0]  match_s [2];

  logic          fail_o [2];
  logic          go_o   [2];
  logic [CW-1:0] cnt_o  [2];
  logic [AW-1:0] ff_o   [2];
`ifdef BCAM_MBIST_OUTHANDLER_DIAG_EN
  logic [N-1:0]  vec_o  [2];
`endif

  outcome_t     sbq [2][$];
  logic [N-1:0] plan_match [MAXC];
  bit           rst_hist [MAXC];
  bit           clr_hist [MAXC];
  int           cur = -1;
  int           checks = 0;
  int           failures = 0;

  always #5 bist_clk = ~bist_clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int unsigned LAT = (gi == 0) ? 1 : 4;
    blk_e0b9f1_if #(.RF_ENTRIES(N), .RF_AWIDTH(AW), .FAILCNT_WIDTH(CW)) bus ();
    assign bus.BIST_CM_MODE_RF_IN     = mode_v;
    assign bus.BIST_CM_EXP_MODE_RF_IN = exp_mode;
    assign bus.BIST_CM_EXP_ADDR_RF_IN = exp_addr;
    assign bus.CM_MATCH_RF_IN         = match_s[gi];
    assign bus.BIST_CMP_CLR_RF_IN     = clr;
    assign fail_o[gi] = bus.BIST_CM_FAIL_RF_OUT;
    assign go_o[gi]   = bus.BIST_CM_GO_ID_RF_OUT;
    assign cnt_o[gi]  = bus.BIST_CM_FAIL_CNT_RF_OUT;
    assign ff_o[gi]   = bus.BIST_CM_FF_ADDR_RF_OUT;
`ifdef BCAM_MBIST_OUTHANDLER_DIAG_EN
    assign vec_o[gi]  = bus.BIST_CM_FAIL_VEC_RF_OUT;
`endif
    blk_e0b9f1 #(.RF_ENTRIES(N), .RF_AWIDTH(AW), .CM_LATENCY(LAT), .FAILCNT_WIDTH(CW)) dut (
      .bist_clk (bist_clk),
      .rst      (rst),
      .bus      (bus)
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [N-1:0] onehot(input int b);
    logic [N-1:0] one;
    one = N'(1);
    return one << b;
  endfunction

  function automatic logic [N-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // What the array should return for a compare, from the mode/address rules
  function automatic logic [N-1:0] ideal_vec(input logic [1:0] m, input logic [AW-1:0] a);
    case (m)
      2'b00:   return '0;
      2'b01:   return onehot(int'(a));
      default: return '1;
    endcase
  endfunction

  // Outcome of one issued compare given the match vector the array will return
  function automatic outcome_t expect_of(input bit v, input logic [1:0] m,
                                         input logic [AW-1:0] a, input logic [N-1:0] mt);
    outcome_t     o;
    logic [N-1:0] sh;
    o.due = 0; o.fail = 1'b0; o.idx = 0; o.xv = '0;
    if (!v || m == 2'b11 || (m == 2'b01 && int'(a) >= int'(N))) return o;
    o.xv   = mt ^ ideal_vec(m, a);
    o.fail = (o.xv != '0);
    sh = o.xv;
    for (int b = 0; b < int'(N); b++) begin
      if (sh[0]) begin
        o.idx = b;
        break;
      end
      sh = sh >> 1;
    end
    return o;
  endfunction

  task automatic chk(input string nm, input int i, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s lat=%0d cyc=%0d actual=%0h required=%0h", nm, lat_of(i), cur, act, req);
    end
  endtask

  // One clock of stimulus; schedules each instance's match and the expected outcome
  task automatic do_cycle(input bit v, input logic [1:0] m, input logic [AW-1:0] a,
                          input logic [N-1:0] mt, input bit c, input bit r);
    outcome_t o;
    @(posedge bist_clk);
    #1;
    cur++;
    if (cur >= int'(MAXC)) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cur, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    rst = r; mode_v = v; exp_mode = m; exp_addr = a; clr = c;
    plan_match[cur] = mt;
    rst_hist[cur]   = r;
    clr_hist[cur]   = c;
    for (int i = 0; i < 2; i++) begin
      if (cur >= lat_of(i)) match_s[i] = plan_match[cur - lat_of(i)];
      else                  match_s[i] = rnd_vec();
    end
    if (r) begin
      sbq[0].delete();
      sbq[1].delete();
    end else begin
      o = expect_of(v, m, a, mt);
      for (int i = 0; i < 2; i++) begin
        o.due = cur + lat_of(i) + 1;
        sbq[i].push_back(o);
      end
    end
  endtask

  task automatic idle();
    do_cycle(1'b0, 2'b00, '0, rnd_vec(), 1'b0, 1'b0);
  endtask

  task automatic clear_cycle();
    do_cycle(1'b0, 2'b00, '0, rnd_vec(), 1'b1, 1'b0);
  endtask

  // Monitor: status model advanced by the outcome registered at the previous edge
  outcome_t     mo;
  bit           efail;
  bit           m_go  [2];
  int           m_cnt [2];
  int           m_ff  [2];
  logic [N-1:0] m_vec [2];

  always @(negedge bist_clk) begin
    if (cur >= 0) begin
      for (int i = 0; i < 2; i++) begin
        efail = 1'b0;
        if (rst_hist[cur] || (cur > 0 && rst_hist[cur-1])) begin
          m_go[i] = 1'b0; m_cnt[i] = 0; m_ff[i] = 0; m_vec[i] = '0;
        end else begin
          if (sbq[i].size() > 0 && sbq[i][0].due == cur) begin
            mo    = sbq[i].pop_front();
            efail = mo.fail;
          end
          if (cur > 0 && clr_hist[cur-1]) begin
            m_go[i] = 1'b0; m_cnt[i] = 0; m_ff[i] = 0; m_vec[i] = '0;
          end else if (efail) begin
            if (!m_go[i]) begin
              m_ff[i]  = mo.idx;
              m_vec[i] = mo.xv;
            end
            m_go[i] = 1'b1;
            if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
          end
        end
        chk("fail_pulse", i, N'(fail_o[i]), N'(efail));
        chk("go_id",      i, N'(go_o[i]),   N'(m_go[i]));
        chk("fail_cnt",   i, N'(cnt_o[i]),  N'(m_cnt[i]));
        chk("ff_addr",    i, N'(ff_o[i]),   N'(m_ff[i]));
`ifdef BCAM_MBIST_OUTHANDLER_DIAG_EN
        chk("fail_vec",   i, vec_o[i],      m_vec[i]);
`endif
      end
    end
  end

  initial begin
    logic [N-1:0]  stuck;
    logic [N-1:0]  base;
    logic [1:0]    rm;
    logic [AW-1:0] ra;
    match_s[0] = '0;
    match_s[1] = '0;
    stuck      = '1;
    stuck      = stuck ^ onehot(127);

    repeat (3) do_cycle(1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
    repeat (4) idle();

    // exact single hit: no fail
    do_cycle(1'b1, 2'b01, 7'd5, onehot(5), 1'b0, 1'b0);
    repeat (6) idle();
    // extra hit on entry 9: first fail
    do_cycle(1'b1, 2'b01, 7'd5, onehot(5) | onehot(9), 1'b0, 1'b0);
    repeat (6) idle();

    // all-hit with entry 127 stuck: counter saturation, back-to-back
    clear_cycle();
    repeat (2) idle();
    repeat (300) do_cycle(1'b1, 2'b10, '0, stuck, 1'b0, 1'b0);
    repeat (6) idle();

    // skip mode with random match, then clean no-hit
    clear_cycle();
    repeat (2) idle();
    do_cycle(1'b1, 2'b11, 7'($urandom_range(0, 127)), rnd_vec(), 1'b0, 1'b0);
    do_cycle(1'b1, 2'b00, 7'($urandom_range(0, 127)), '0, 1'b0, 1'b0);
    repeat (6) idle();

    // clear in the cycle the fail pulse shows (cycle +2 for lat 1, +5 for lat 4)
    do_cycle(1'b1, 2'b00, '0, onehot(77) | onehot(100), 1'b0, 1'b0);
    idle();
    clear_cycle();
    idle();
    idle();
    clear_cycle();
    repeat (3) idle();
    do_cycle(1'b1, 2'b00, '0, onehot(33) | onehot(90), 1'b0, 1'b0);
    repeat (6) idle();

    // reset while a failing compare is in flight, then a post-reset compare
    do_cycle(1'b1, 2'b10, '0, stuck, 1'b0, 1'b0);
    do_cycle(1'b0, 2'b00, '0, rnd_vec(), 1'b0, 1'b1);
    repeat (2) idle();
    do_cycle(1'b1, 2'b01, 7'd12, onehot(12) | onehot(3), 1'b0, 1'b0);
    repeat (6) idle();

    // randomized traffic with occasional clear and reset
    repeat (500) begin
      rm = 2'($urandom_range(0, 3));
      ra = 7'($urandom_range(0, 127));
      base = (rm == 2'b11) ? rnd_vec() : ideal_vec(rm, ra);
      case ($urandom_range(0, 3))
        0:       base = base;
        1:       base = base ^ onehot(int'($urandom_range(0, 127)));
        2:       base = base ^ onehot(int'($urandom_range(0, 127))) ^ onehot(int'($urandom_range(0, 127)));
        default: base = rnd_vec();
      endcase
      do_cycle(($urandom_range(0, 9) < 7), rm, ra, base,
               ($urandom_range(0, 24) == 0), ($urandom_range(0, 199) == 0));
    end
    repeat (8) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
